pipe_fwd_chain: RTL

PIPE_FWD_CHAIN -- requirements
Module: pipe_fwd_chain

---
 rtl/pipe_fwd_chain.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipe_fwd_chain.sv
// rtl/pipe_fwd_chain.sv - result pipeline with youngest-match forwarding, load-use stall and writeback
// Forwarding paths are built only when PIPE_FWD_EN is defined; otherwise every hazard stalls.
module pipe_fwd_chain #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int DEPTH    = 3,
    parameter int LATE_STG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_wen,
    input  logic              in_rdy,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] late_data,
    input  logic              hold,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data,
    output logic              stall_req,
    output logic              wb_valid,
    output logic              wb_wen,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       stall_cnt
);
    logic [DEPTH-1:0]             stValid;
    logic [DEPTH-1:0]             stWen;
    logic [DEPTH-1:0]             stRdy;
    logic [DEPTH-1:0][REG_AW-1:0] stRd;
    logic [DEPTH-1:0][DATA_W-1:0] stData;
    logic                         match1;
    logic                         match2;
    logic                         loadOk;
`ifdef PIPE_FWD_EN
    logic                         rdy1;
    logic                         rdy2;
    logic [DATA_W-1:0]            data1;
    logic [DATA_W-1:0]            data2;
`endif

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
`ifdef PIPE_FWD_EN
        rdy1   = 1'b0;
        rdy2   = 1'b0;
        data1  = '0;
        data2  = '0;
`endif
        // Scan oldest to youngest so the youngest matching stage wins.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (stValid[k] && stWen[k] && (rs1 != '0) && (stRd[k] == rs1)) begin
                match1 = 1'b1;
`ifdef PIPE_FWD_EN
                rdy1   = stRdy[k];
                data1  = stData[k];
`endif
            end
            if (stValid[k] && stWen[k] && (rs2 != '0) && (stRd[k] == rs2)) begin
                match2 = 1'b1;
`ifdef PIPE_FWD_EN
                rdy2   = stRdy[k];
                data2  = stData[k];
`endif
            end
        end
    end

`ifdef PIPE_FWD_EN
    assign stall_req = (match1 && !rdy1) || (match2 && !rdy2);
    assign fwd1_hit  = match1 && rdy1;
    assign fwd2_hit  = match2 && rdy2;
    assign fwd1_data = fwd1_hit ? data1 : '0;
    assign fwd2_data = fwd2_hit ? data2 : '0;
`else
    logic unusedRdy;
    assign unusedRdy = stRdy[DEPTH-1];
    assign stall_req = match1 || match2;
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

    assign loadOk = !stall_req && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stValid   <= '0;
            stWen     <= '0;
            stRdy     <= '0;
            stRd      <= '0;
            stData    <= '0;
            stall_cnt <= '0;
        end else begin
            if (!hold) begin
                for (int k = 1; k < DEPTH; k++) begin
                    stValid[k] <= stValid[k-1];
                    stWen[k]   <= stWen[k-1];
                    stRd[k]    <= stRd[k-1];
                    // Pending load picks up its data as it crosses into the late stage.
                    if (k == LATE_STG && stValid[k-1] && !stRdy[k-1]) begin
                        stRdy[k]  <= 1'b1;
                        stData[k] <= late_data;
                    end else begin
                        stRdy[k]  <= stRdy[k-1];
                        stData[k] <= stData[k-1];
                    end
                end
                stValid[0] <= loadOk && in_valid;
                stWen[0]   <= loadOk && in_wen;
                stRdy[0]   <= loadOk && in_rdy;
                stRd[0]    <= loadOk ? in_rd : '0;
                stData[0]  <= loadOk ? in_data : '0;
            end else if (flush) begin
                stValid[0] <= 1'b0;
            end
            if (stall_req && !hold && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign wb_valid = stValid[DEPTH-1] && !hold;
    assign wb_wen   = stWen[DEPTH-1];
    assign wb_rd    = stRd[DEPTH-1];
    assign wb_data  = stData[DEPTH-1];

endmodule
